// File: rtl/serial_mag_cmp.sv
// Bit-serial MSB-first magnitude comparator: loads A/B on start, reports eq/gt/lt with a one-cycle done pulse.
// Optional macro SERIAL_MAG_CMP_SIGNED_EN selects two's-complement comparison.
module serial_mag_cmp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sa, sb, sa_n, sb_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             e, g, e_n, g_n;
    logic             eq_n, gt_n, lt_n;
    logic             x, y, diff, g_upd;

    assign x    = sa[WIDTH-1];
    assign y    = sb[WIDTH-1];
    assign diff = x ^ y;

    assign busy = (state == RUN);
    assign done = (state == DONE);

`ifdef SERIAL_MAG_CMP_SIGNED_EN
    // A sign-bit mismatch inverts the verdict: the operand with a 0 sign bit is larger.
    always_comb begin
        g_upd = g;
        if (diff) begin
            if (cnt == CW'(WIDTH))
                g_upd = ~x;
            else
                g_upd = x;
        end
    end
`else
    always_comb begin
        g_upd = g;
        if (diff)
            g_upd = x;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            cnt   <= '0;
            e     <= 1'b1;
            g     <= 1'b0;
            eq    <= 1'b0;
            gt    <= 1'b0;
            lt    <= 1'b0;
        end else begin
            state <= state_n;
            sa    <= sa_n;
            sb    <= sb_n;
            cnt   <= cnt_n;
            e     <= e_n;
            g     <= g_n;
            eq    <= eq_n;
            gt    <= gt_n;
            lt    <= lt_n;
        end
    end

    // Results only move on the edge that enters DONE; otherwise they hold.
    always_comb begin
        state_n = state;
        sa_n    = sa;
        sb_n    = sb;
        cnt_n   = cnt;
        e_n     = e;
        g_n     = g;
        eq_n    = eq;
        gt_n    = gt;
        lt_n    = lt;

        unique case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (start) begin
                    sa_n    = a;
                    sb_n    = b;
                    cnt_n   = CW'(WIDTH);
                    e_n     = 1'b1;
                    g_n     = 1'b0;
                    state_n = RUN;
                end
            end
            RUN: begin
                e_n   = e & ~diff;
                g_n   = g_upd;
                sa_n  = sa << 1;
                sb_n  = sb << 1;
                cnt_n = cnt - CW'(1);
                if (diff || (cnt == CW'(1))) begin
                    eq_n    = ~diff;
                    gt_n    = diff & g_upd;
                    lt_n    = diff & ~g_upd;
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Scoreboard bench for serial_mag_cmp: driver pushes model predictions, negedge monitor checks outputs.
module tb_serial_mag_cmp;

    localparam int W = 8;

    typedef struct {
        logic eq;
        logic gt;
        logic lt;
        int   done_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, eq, gt, lt;

    int   cyc = 0;
    int   next_free = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t held = '{eq: 1'b0, gt: 1'b0, lt: 1'b0, done_cyc: 0};

    serial_mag_cmp #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .eq   (eq),
        .gt   (gt),
        .lt   (lt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference: result from plain integer comparison, latency from the first differing bit.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input int acc);
        exp_t r;
        int   k;
        bit   found;
        k = W;
        found = 0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found && av[i] != bv[i]) begin
                k = W - i;
                found = 1;
            end
        end
        r.eq = (av == bv);
`ifdef SERIAL_MAG_CMP_SIGNED_EN
        r.gt = ($signed(av) > $signed(bv));
`else
        r.gt = (av > bv);
`endif
        r.lt = !r.eq && !r.gt;
        r.done_cyc = acc + k;
        return r;
    endfunction

    task automatic checkOutput(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
        logic accepting;
        exp_t e;
        @(negedge clk);
        accepting = s && !rst && (cyc >= next_free);
        start = s;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        if (accepting) begin
            e = model(av, bv, cyc);
            q.push_back(e);
            next_free = e.done_cyc;
        end
    endtask

    task automatic runOne(input logic [W-1:0] av, input logic [W-1:0] bv);
        int guard;
        guard = 0;
        while (cyc < next_free && guard < 100) begin
            applyStimulus(1'b0, av, bv);
            guard++;
        end
        applyStimulus(1'b1, av, bv);
    endtask

    // Monitor: compares status every cycle and pops the scoreboard on the expected done cycle.
    always @(negedge clk) begin
        logic exp_done, exp_busy;
        if (rst) begin
            q.delete();
            held = '{eq: 1'b0, gt: 1'b0, lt: 1'b0, done_cyc: 0};
            checkOutput("reset_busy", int'(busy), 0);
            checkOutput("reset_done", int'(done), 0);
            checkOutput("reset_eq", int'(eq), 0);
            checkOutput("reset_gt", int'(gt), 0);
            checkOutput("reset_lt", int'(lt), 0);
        end else begin
            exp_done = (q.size() > 0) && (cyc == q[0].done_cyc);
            exp_busy = (q.size() > 0) && (cyc < q[0].done_cyc);
            checkOutput("done", int'(done), int'(exp_done));
            checkOutput("busy", int'(busy), int'(exp_busy));
            if (exp_done) begin
                held = q[0];
                void'(q.pop_front());
            end
            checkOutput("eq", int'(eq), int'(held.eq));
            checkOutput("gt", int'(gt), int'(held.gt));
            checkOutput("lt", int'(lt), int'(held.lt));
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int guard;
        logic [W-1:0] ra, rb;
        int mode;

        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        $display("[TB] directed cases");
        runOne(8'hA5, 8'hA5);
        runOne(8'h80, 8'h7F);
        runOne(8'h12, 8'h13);
        runOne(8'h13, 8'h12);
        runOne(8'hFF, 8'h01);
        runOne(8'h7F, 8'h80);
        runOne(8'h00, 8'hFF);

        $display("[TB] start held high with changing operands");
        for (int i = 0; i < 40; i++)
            applyStimulus(1'b1, W'($urandom), W'($urandom));

        $display("[TB] reset mid-operation");
        runOne(8'h01, 8'h00);
        repeat (3) applyStimulus(1'b0, W'($urandom), W'($urandom));
        rst = 1'b1;
        next_free = 0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        runOne(8'h01, 8'h00);

        $display("[TB] randomized comparisons");
        for (int i = 0; i < 150; i++) begin
            ra = W'($urandom);
            mode = $urandom_range(0, 3);
            case (mode)
                0: rb = W'($urandom);
                1: rb = ra;
                2: rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
                default: rb = ra ^ W'($urandom_range(0, 7));
            endcase
            runOne(ra, rb);
            repeat ($urandom_range(0, 2)) applyStimulus(1'b0, ra, rb);
        end

        guard = 0;
        while (q.size() > 0 && guard < 200) begin
            applyStimulus(1'b0, '0, '0);
            guard++;
        end
        applyStimulus(1'b0, '0, '0);
        checkOutput("drain_queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
